// File: rtl/frame_buf_pkg.sv
// Shared constants and FSM encoding for the thermal frame ping-pong buffer.
package frame_buf_pkg;

  localparam int unsigned ADDR_WIDTH  = 14;
  localparam int unsigned FRAME_BYTES = 1536;
  localparam int unsigned DROP_WIDTH  = 8;
  localparam int unsigned DATA_WIDTH  = 8;

  typedef enum logic [0:0] {
    ST_FILL    = 1'b0,
    ST_PUBLISH = 1'b1
  } fb_state_t;

endpackage

// File: rtl/cs_synchronizer.sv
// Two-flop synchroniser for the raw SPI chip select plus a falling-edge
// detector on the synchronised level.
module cs_synchronizer (
  input  logic clk,
  input  logic reset,
  input  logic cs_raw,
  output logic cs_s,
  output logic cs_fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= cs_raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign cs_s    = sync;
  assign cs_fall = prev & ~sync;

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Ping-pong arbiter: capture fills the write bank while SPI reads the other;
// banks swap after a completed frame, only while chip select is idle.
module frame_buffer_arbiter #(
  parameter int unsigned ADDR_WIDTH  = frame_buf_pkg::ADDR_WIDTH,
  parameter int unsigned FRAME_BYTES = frame_buf_pkg::FRAME_BYTES,
  parameter int unsigned DROP_WIDTH  = frame_buf_pkg::DROP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [7:0]            wr_data,
  input  logic                  wr_last,
  input  logic                  spi_cs,
  input  logic [ADDR_WIDTH-1:0] spi_addr,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH:0]   mem_wr_addr,
  output logic [7:0]            mem_wr_data,
  output logic [ADDR_WIDTH:0]   mem_rd_addr,
  output logic                  frame_ready,
  output logic                  length_err,
  output logic [DROP_WIDTH-1:0] drop_count
);

  import frame_buf_pkg::fb_state_t;
  import frame_buf_pkg::ST_FILL;
  import frame_buf_pkg::ST_PUBLISH;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_BYTES - 1);

  fb_state_t             state;
  logic [ADDR_WIDTH-1:0] byte_index;
  logic                  read_bank;
  logic                  write_bank;
  logic                  overflow;
  logic                  cs_s;
  logic                  cs_fall;
  logic                  accept;
  logic                  at_last_slot;
  logic                  swap;

  cs_synchronizer u_cs_sync (
    .clk     (clk),
    .reset   (reset),
    .cs_raw  (spi_cs),
    .cs_s    (cs_s),
    .cs_fall (cs_fall)
  );

  assign write_bank   = ~read_bank;
  assign accept       = wr_valid & wr_ready;
  assign at_last_slot = (byte_index == LAST_IDX);
  assign swap         = (state == ST_PUBLISH) & ~cs_s;

  // RAM ports; an overlong frame keeps being accepted but stops writing.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_addr = {write_bank, byte_index};
    mem_wr_data = wr_data;
    mem_rd_addr = {read_bank, spi_addr};
    if (accept && !overflow && !reset) begin
      mem_wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FILL;
      read_bank   <= 1'b1;
      byte_index  <= '0;
      overflow    <= 1'b0;
      wr_ready    <= 1'b1;
      frame_ready <= 1'b0;
      length_err  <= 1'b0;
      drop_count  <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            if (!overflow) begin
              if (!at_last_slot) begin
                byte_index <= byte_index + ADDR_WIDTH'(1);
              end else if (!wr_last) begin
                overflow   <= 1'b1;
                length_err <= 1'b1;
              end
            end
            if (wr_last) begin
              if (!at_last_slot) begin
                length_err <= 1'b1;
              end
              state    <= ST_PUBLISH;
              wr_ready <= 1'b0;
            end
          end
        end
        ST_PUBLISH: begin
          // Bank flip is held off while a read transaction may be in flight.
          if (swap) begin
            read_bank  <= ~read_bank;
            byte_index <= '0;
            overflow   <= 1'b0;
            state      <= ST_FILL;
            wr_ready   <= 1'b1;
            if (frame_ready && (drop_count != '1)) begin
              drop_count <= drop_count + DROP_WIDTH'(1);
            end
          end
        end
      endcase

      // A fresh frame outranks the end of the transaction that read the old one.
      if (swap) begin
        frame_ready <= 1'b1;
      end else if (cs_fall) begin
        frame_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Randomised bench for frame_buffer_arbiter with a frame-level reference model.
module tb_frame_buffer_arbiter;

  localparam int AW = 14;
  localparam int FB = 1536;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [7:0]    wr_data;
  logic          wr_last;
  logic          spi_cs;
  logic [AW-1:0] spi_addr;
  logic          mem_wr_en;
  logic [AW:0]   mem_wr_addr;
  logic [7:0]    mem_wr_data;
  logic [AW:0]   mem_rd_addr;
  logic          frame_ready;
  logic          length_err;
  logic [DW-1:0] drop_count;

  frame_buffer_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .spi_cs      (spi_cs),
    .spi_addr    (spi_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_addr (mem_rd_addr),
    .frame_ready (frame_ready),
    .length_err  (length_err),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: bank of the readable frame, frame/error/drop status,
  // bytes taken into the frame being filled, and a frame awaiting a swap.
  bit m_valid = 1'b0;
  bit m_rb, m_fr, m_lerr, m_pub;
  int m_drops, m_count;
  bit cs_d1, cs_d2, cs_d3;   // raw CS as seen at the last three edges

  int total = 0;
  int bad = 0;
  int n_wen;
  bit first_seen;
  bit cs_random;
  logic [AW:0] first_addr, last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare at negedge, advance the model over the posedge.
  task automatic step();
    bit exp_ready, acc, exp_wen, cs_sync, fall, swp;
    @(negedge clk);
    exp_ready = !m_pub;
    acc       = wr_valid && exp_ready;
    exp_wen   = acc && !reset && (m_count < FB);
    if (m_valid) begin
      chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_wen));
      if (exp_wen) begin
        chk("mem_wr_addr", 32'(mem_wr_addr), (m_rb ? 32'h0 : 32'h4000) + 32'(m_count));
        chk("mem_wr_data", 32'(mem_wr_data), 32'(wr_data));
      end
      chk("mem_rd_addr", 32'(mem_rd_addr), (m_rb ? 32'h4000 : 32'h0) + 32'(spi_addr));
      chk("frame_ready", 32'(frame_ready), 32'(m_fr));
      chk("length_err", 32'(length_err), 32'(m_lerr));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
    end
    if (mem_wr_en) begin
      n_wen++;
      if (!first_seen) first_addr = mem_wr_addr;
      first_seen = 1'b1;
      last_addr  = mem_wr_addr;
    end
    if (reset) begin
      m_valid = 1'b1; m_rb = 1'b1; m_fr = 1'b0; m_lerr = 1'b0; m_pub = 1'b0;
      m_drops = 0; m_count = 0; cs_d1 = 1'b0; cs_d2 = 1'b0; cs_d3 = 1'b0;
    end else if (m_valid) begin
      cs_sync = cs_d2;
      fall    = !cs_d2 && cs_d3;
      swp     = m_pub && !cs_sync;
      if (swp) begin
        if (m_fr && m_drops < 255) m_drops++;
        m_rb = !m_rb; m_count = 0; m_pub = 1'b0;
      end else if (acc) begin
        if (wr_last ? (m_count != FB - 1) : (m_count == FB - 1)) m_lerr = 1'b1;
        m_count++;
        if (wr_last) m_pub = 1'b1;
      end
      if (swp) m_fr = 1'b1;
      else if (fall) m_fr = 1'b0;
      cs_d3 = cs_d2; cs_d2 = cs_d1; cs_d1 = spi_cs;
    end
    @(posedge clk);
    #1;
    spi_addr = AW'($urandom);
    if (cs_random && $urandom_range(0, 39) == 0) spi_cs = !spi_cs;
  endtask

  task automatic idle(input int n);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input int n, input bit with_last, input bit rnd, input bit bubbles);
    int i = 0;
    int guard = 0;
    while (i < n) begin
      wr_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_data  = rnd ? 8'($urandom) : 8'(i);
      wr_last  = with_last && (i == n - 1);
      if (wr_valid && !m_pub) i++;
      step();
      guard++;
      if (guard > 20000) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got %0d bytes expected %0d", i, n);
        break;
      end
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    reset    = 1'b1;
    idle(2);
    reset    = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    spi_cs = 1'b0; spi_addr = '0; cs_random = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("rst_frame_ready", 32'(frame_ready), 32'd0);
    chk("rst_read_bank", 32'(mem_rd_addr[AW]), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_drop_count", 32'(drop_count), 32'd0);

    // Counting-pattern frame on an idle bus.
    n_wen = 0; first_seen = 1'b0;
    send(FB, 1'b1, 1'b0, 1'b0);
    chk("t1_writes", 32'(n_wen), 32'd1536);
    chk("t1_first_addr", 32'(first_addr), 32'h0000);
    chk("t1_last_addr", 32'(last_addr), 32'h05FF);
    chk("t1_publish_ready", 32'(wr_ready), 32'd0);
    idle(1);
    chk("t1_read_bank", 32'(mem_rd_addr[AW]), 32'd0);
    chk("t1_frame_ready", 32'(frame_ready), 32'd1);
    spi_addr = 14'h0123;
    #1;
    chk("t1_rd_addr", 32'(mem_rd_addr), 32'h0123);

    // Frame completes while CS is held high; swap waits for the synchronised drop.
    spi_cs = 1'b1;
    idle(3);
    send(FB, 1'b1, 1'b1, 1'b1);
    repeat (6) begin
      step();
      chk("t2_held_ready", 32'(wr_ready), 32'd0);
      chk("t2_held_bank", 32'(mem_rd_addr[AW]), 32'd0);
    end
    spi_cs = 1'b0;
    step();
    chk("t2_bank_clk1", 32'(mem_rd_addr[AW]), 32'd0);
    step();
    chk("t2_bank_clk2", 32'(mem_rd_addr[AW]), 32'd0);
    step();
    chk("t2_bank_clk3", 32'(mem_rd_addr[AW]), 32'd1);
    chk("t6_fall_vs_swap", 32'(frame_ready), 32'd1);
    chk("t2_ready_back", 32'(wr_ready), 32'd1);

    // Unread frames overwritten back to back.
    do_reset();
    send(FB, 1'b1, 1'b1, 1'b1); idle(1);
    chk("t3_drop0", 32'(drop_count), 32'd0);
    send(FB, 1'b1, 1'b1, 1'b1); idle(1);
    chk("t3_drop1", 32'(drop_count), 32'd1);
    chk("t3_ready1", 32'(frame_ready), 32'd1);
    send(FB, 1'b1, 1'b1, 1'b1); idle(1);
    chk("t3_drop2", 32'(drop_count), 32'd2);
    repeat (260) begin
      send(1, 1'b1, 1'b1, 1'b0);
      idle(1);
    end
    chk("t3_drop_sat", 32'(drop_count), 32'd255);
    spi_cs = 1'b1; idle(4);
    spi_cs = 1'b0; idle(4);
    chk("t3_cs_clears_ready", 32'(frame_ready), 32'd0);
    chk("t3_drop_hold", 32'(drop_count), 32'd255);

    // Short frame, then overlong frame.
    do_reset();
    send(1001, 1'b1, 1'b1, 1'b1); idle(1);
    chk("t4_short_err", 32'(length_err), 32'd1);
    chk("t4_short_published", 32'(frame_ready), 32'd1);
    chk("t4_short_bank", 32'(mem_rd_addr[AW]), 32'd0);
    do_reset();
    n_wen = 0;
    send(1600, 1'b1, 1'b1, 1'b1);
    chk("t4_long_writes", 32'(n_wen), 32'd1536);
    idle(1);
    chk("t4_long_err", 32'(length_err), 32'd1);
    chk("t4_long_published", 32'(frame_ready), 32'd1);

    // Reset in the middle of a frame.
    do_reset();
    send(700, 1'b0, 1'b1, 1'b0);
    wr_valid = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("t5_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("t5_read_bank", 32'(mem_rd_addr[AW]), 32'd1);
    chk("t5_frame_ready", 32'(frame_ready), 32'd0);
    send(FB, 1'b1, 1'b1, 1'b1); idle(1);
    chk("t5_republish", 32'(frame_ready), 32'd1);
    chk("t5_no_err", 32'(length_err), 32'd0);
    chk("t5_bank", 32'(mem_rd_addr[AW]), 32'd0);

    // Random frames against random CS activity.
    do_reset();
    cs_random = 1'b1;
    repeat (8) begin
      int len;
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 1700)) : FB;
      send(len, 1'b1, 1'b1, 1'b1);
      idle(int'($urandom_range(1, 6)));
    end
    cs_random = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
